// File: rtl/decode_ctrl_pipe_pkg.sv
// riscv_ctrl_pkg: opcode, ALU, result/immediate encodings and the control bundle for decode_ctrl_pipe
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;
    typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
    typedef enum logic [2:0] {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_ILL} op_class_t;

    typedef struct packed {
        logic        reg_we;
        logic        mem_we;
        logic        src_b;
        result_src_t result;
        logic        branch;
        logic        jump;
    } ctrl_t;

    function automatic op_class_t classify(input logic [6:0] opc);
        return opc == OPC_LW  ? OP_LW  :
               opc == OPC_SW  ? OP_SW  :
               opc == OPC_R   ? OP_R   :
               opc == OPC_I   ? OP_I   :
               opc == OPC_BEQ ? OP_BEQ :
               opc == OPC_JAL ? OP_JAL : OP_ILL;
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_alu_decoder.sv
// alu_decoder: maps opcode class, funct3 and funct7[5] to an ALU operation and flags unsupported funct3
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  op_class_t  op_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       illegal_funct
);

    logic arith;

    assign arith = (op_class == OP_R) || (op_class == OP_I);

    always_comb begin
        alu_ctrl      = ALU_AND;
        illegal_funct = 1'b0;
        if (op_class == OP_LW || op_class == OP_SW)
            alu_ctrl = ALU_ADD;
        else if (op_class == OP_BEQ)
            alu_ctrl = ALU_SUB;
        else if (arith)
            case (funct3)
                3'b000:  alu_ctrl = (op_class == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: illegal_funct = 1'b1;
            endcase
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RISC-V decode, D->E control register, load-use stall and branch flush; DECODE_CTRL_ILLEGAL_CNT_EN adds an illegal-instruction counter
module decode_ctrl_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 3,
    parameter int REG_ADDR_W    = 5,
    parameter int ILLEGAL_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instr_D,
    input  logic                     valid_D,
    input  logic                     branch_taken_E,
    output logic [1:0]               imm_src_D,
    output logic                     stall_F,
    output logic                     stall_D,
    output logic                     flush_E,
    output logic                     valid_E,
    output logic                     ctrl_register_file_WE_E,
    output logic                     ctrl_data_memory_WE_E,
    output logic                     ctrl_srcB_E,
    output logic [1:0]               ctrl_result_E,
    output logic                     ctrl_branch_E,
    output logic                     ctrl_jump_E,
    output logic [ALU_CTRL_W-1:0]    ctrl_ALU_control_E,
    output logic [REG_ADDR_W-1:0]    rd_E,
    output logic                     illegal_E,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

    op_class_t             op_class;
    logic [2:0]            alu_ctrl;
    logic                  illegal_funct;
    logic                  illegal;
    logic                  lw_stall;
    ctrl_t                 ctrl_D;
    ctrl_t                 ctrl_E;
    logic [REG_ADDR_W-1:0] rd_D;
    logic [REG_ADDR_W-1:0] rs1_D;
    logic [REG_ADDR_W-1:0] rs2_D;
    logic                  unused_instr;

    assign op_class     = classify(instr_D[6:0]);
    assign rd_D         = REG_ADDR_W'(instr_D[11:7]);
    assign rs1_D        = REG_ADDR_W'(instr_D[19:15]);
    assign rs2_D        = REG_ADDR_W'(instr_D[24:20]);
    assign unused_instr = ^{instr_D[31], instr_D[29:25]};

    alu_decoder u_alu_decoder (
        .op_class      (op_class),
        .funct3        (instr_D[14:12]),
        .funct7_5      (instr_D[30]),
        .alu_ctrl      (alu_ctrl),
        .illegal_funct (illegal_funct)
    );

    assign illegal = (op_class == OP_ILL) | illegal_funct;

    always_comb begin
        ctrl_D    = '0;
        imm_src_D = IMM_I;
        case (op_class)
            OP_LW:   begin ctrl_D.reg_we = 1'b1; ctrl_D.src_b = 1'b1; ctrl_D.result = RES_MEM; end
            OP_SW:   begin ctrl_D.mem_we = 1'b1; ctrl_D.src_b = 1'b1; imm_src_D = IMM_S; end
            OP_R:    ctrl_D.reg_we = 1'b1;
            OP_I:    begin ctrl_D.reg_we = 1'b1; ctrl_D.src_b = 1'b1; end
            OP_BEQ:  begin ctrl_D.branch = 1'b1; imm_src_D = IMM_B; end
            OP_JAL:  begin ctrl_D.reg_we = 1'b1; ctrl_D.jump = 1'b1; ctrl_D.result = RES_PC4; imm_src_D = IMM_J; end
            default: ctrl_D = '0;
        endcase
        if (illegal)
            ctrl_D = '0;
    end

    // Conservative: both source fields are compared whatever the D opcode
    assign lw_stall = valid_D & valid_E & (ctrl_E.result == RES_MEM) & (rd_E != '0) &
                      ((rd_E == rs1_D) | (rd_E == rs2_D));
    assign stall_F  = lw_stall;
    assign stall_D  = lw_stall;
    assign flush_E  = lw_stall | branch_taken_E;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_E             <= '0;
            ctrl_ALU_control_E <= '0;
            rd_E               <= '0;
            valid_E            <= 1'b0;
            illegal_E          <= 1'b0;
        end else if (flush_E) begin
            ctrl_E             <= '0;
            ctrl_ALU_control_E <= '0;
            rd_E               <= '0;
            valid_E            <= 1'b0;
            illegal_E          <= 1'b0;
        end else begin
            ctrl_E             <= valid_D ? ctrl_D : '0;
            ctrl_ALU_control_E <= valid_D ? ALU_CTRL_W'(alu_ctrl) : '0;
            rd_E               <= valid_D ? rd_D : '0;
            valid_E            <= valid_D;
            illegal_E          <= valid_D & illegal;
        end
    end

    assign ctrl_register_file_WE_E = ctrl_E.reg_we;
    assign ctrl_data_memory_WE_E   = ctrl_E.mem_we;
    assign ctrl_srcB_E             = ctrl_E.src_b;
    assign ctrl_result_E           = ctrl_E.result;
    assign ctrl_branch_E           = ctrl_E.branch;
    assign ctrl_jump_E             = ctrl_E.jump;

`ifdef DECODE_CTRL_ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (valid_D & illegal & ~flush_E & ~&illegal_cnt)
            illegal_cnt <= illegal_cnt + ILLEGAL_CNT_W'(1);
    end
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed self-checking bench for decode_ctrl_pipe (with or without DECODE_CTRL_ILLEGAL_CNT_EN)
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_D = '0;
    logic        valid_D = 1'b0;
    logic        branch_taken_E = 1'b0;
    logic [1:0]  imm_src_D;
    logic        stall_F, stall_D, flush_E, valid_E;
    logic        ctrl_register_file_WE_E, ctrl_data_memory_WE_E, ctrl_srcB_E;
    logic [1:0]  ctrl_result_E;
    logic        ctrl_branch_E, ctrl_jump_E;
    logic [2:0]  ctrl_ALU_control_E;
    logic [4:0]  rd_E;
    logic        illegal_E;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int failures = 0;

`ifdef DECODE_CTRL_ILLEGAL_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    // Packed E-stage view: valid, WE, memWE, srcB, result[1:0], branch, jump, ALU[2:0], rd[4:0], illegal
    localparam logic [16:0] FULL   = 17'h1FFFF;
    localparam logic [16:0] NO_ALU = 17'h1FE3F;
    localparam logic [16:0] ILL_M  = 17'h1C63F;

    wire [16:0] e_bus = {valid_E, ctrl_register_file_WE_E, ctrl_data_memory_WE_E, ctrl_srcB_E,
                         ctrl_result_E, ctrl_branch_E, ctrl_jump_E, ctrl_ALU_control_E, rd_E, illegal_E};
    wire [2:0]  hz    = {stall_F, stall_D, flush_E};

    always #5 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .instr_D                 (instr_D),
        .valid_D                 (valid_D),
        .branch_taken_E          (branch_taken_E),
        .imm_src_D               (imm_src_D),
        .stall_F                 (stall_F),
        .stall_D                 (stall_D),
        .flush_E                 (flush_E),
        .valid_E                 (valid_E),
        .ctrl_register_file_WE_E (ctrl_register_file_WE_E),
        .ctrl_data_memory_WE_E   (ctrl_data_memory_WE_E),
        .ctrl_srcB_E             (ctrl_srcB_E),
        .ctrl_result_E           (ctrl_result_E),
        .ctrl_branch_E           (ctrl_branch_E),
        .ctrl_jump_E             (ctrl_jump_E),
        .ctrl_ALU_control_E      (ctrl_ALU_control_E),
        .rd_E                    (rd_E),
        .illegal_E               (illegal_E),
        .illegal_cnt             (illegal_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_D = 1'b0;
        branch_taken_E = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        instr_D = 32'h002081B3;
        valid_D = 1'b1;
        tick();
        checks++;
        if (e_bus !== {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,5'd3,1'b0}) begin
            failures++;
            $display("FAIL reset_pre got=%h exp=%h", e_bus, {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,5'd3,1'b0});
        end
        // lw in E then assert reset mid-cycle with a dependent instruction in D
        instr_D = 32'h0000A283;
        tick();
        instr_D = 32'h00228333;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (e_bus !== 17'h0) begin failures++; $display("FAIL reset_e got=%h exp=0", e_bus); end
        checks++;
        if (hz !== 3'b000) begin failures++; $display("FAIL reset_hazard got=%b exp=000", hz); end
        checks++;
        if (illegal_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        valid_D = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] ins [13];
        logic [16:0] exp [13];
        logic [16:0] msk [13];
        logic [2:0]  imm [13];
        ins[0]  = 32'h002081B3; exp[0]  = {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,5'd3,1'b0}; msk[0]  = FULL;   imm[0]  = 3'b000;
        ins[1]  = 32'h402081B3; exp[1]  = {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b110,5'd3,1'b0}; msk[1]  = FULL;   imm[1]  = 3'b000;
        ins[2]  = 32'h0020A1B3; exp[2]  = {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b111,5'd3,1'b0}; msk[2]  = FULL;   imm[2]  = 3'b000;
        ins[3]  = 32'h00508213; exp[3]  = {1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,3'b010,5'd4,1'b0}; msk[3]  = FULL;   imm[3]  = 3'b100;
        ins[4]  = 32'h40008213; exp[4]  = {1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,3'b010,5'd4,1'b0}; msk[4]  = FULL;   imm[4]  = 3'b100;
        ins[5]  = 32'h0050E213; exp[5]  = {1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,3'b001,5'd4,1'b0}; msk[5]  = FULL;   imm[5]  = 3'b100;
        ins[6]  = 32'h0050F213; exp[6]  = {1'b1,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,3'b000,5'd4,1'b0}; msk[6]  = FULL;   imm[6]  = 3'b100;
        ins[7]  = 32'h0000A283; exp[7]  = {1'b1,1'b1,1'b0,1'b1,2'b01,1'b0,1'b0,3'b010,5'd5,1'b0}; msk[7]  = FULL;   imm[7]  = 3'b100;
        ins[8]  = 32'h0020A223; exp[8]  = {1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,3'b010,5'd4,1'b0}; msk[8]  = FULL;   imm[8]  = 3'b101;
        ins[9]  = 32'h00208063; exp[9]  = {1'b1,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'b110,5'd0,1'b0}; msk[9]  = FULL;   imm[9]  = 3'b110;
        ins[10] = 32'h000000EF; exp[10] = {1'b1,1'b1,1'b0,1'b0,2'b10,1'b0,1'b1,3'b000,5'd1,1'b0}; msk[10] = NO_ALU; imm[10] = 3'b111;
        ins[11] = 32'h002091B3; exp[11] = {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,5'd3,1'b1}; msk[11] = ILL_M;  imm[11] = 3'b000;
        ins[12] = 32'h0000007F; exp[12] = {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,5'd0,1'b1}; msk[12] = ILL_M;  imm[12] = 3'b000;
        for (int i = 0; i < 13; i++) begin
            instr_D = ins[i];
            valid_D = 1'b1;
            #1;
            if (imm[i][2]) begin
                checks++;
                if (imm_src_D !== imm[i][1:0]) begin
                    failures++;
                    $display("FAIL imm_src[%0d] got=%b exp=%b", i, imm_src_D, imm[i][1:0]);
                end
            end
            tick();
            checks++;
            if ((e_bus & msk[i]) !== (exp[i] & msk[i])) begin
                failures++;
                $display("FAIL decode[%0d] instr=%h got=%h exp=%h", i, ins[i], e_bus & msk[i], exp[i] & msk[i]);
            end
        end
        // A non-valid D slot is captured as a bubble
        instr_D = 32'h002081B3;
        valid_D = 1'b0;
        tick();
        checks++;
        if (e_bus !== 17'h0) begin failures++; $display("FAIL invalid_bubble got=%h exp=0", e_bus); end
    endtask

    task automatic test_load_use();
        do_reset();
        instr_D = 32'h0000A283;
        valid_D = 1'b1;
        tick();
        instr_D = 32'h00228333;
        #1;
        checks++;
        if (hz !== 3'b111) begin failures++; $display("FAIL load_use_stall got=%b exp=111", hz); end
        tick();
        checks++;
        if (e_bus !== 17'h0) begin failures++; $display("FAIL load_use_bubble got=%h exp=0", e_bus); end
        checks++;
        if (hz !== 3'b000) begin failures++; $display("FAIL load_use_release got=%b exp=000", hz); end
        tick();
        checks++;
        if (e_bus !== {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,5'd6,1'b0}) begin
            failures++;
            $display("FAIL load_use_capture got=%h exp=%h", e_bus, {1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,3'b010,5'd6,1'b0});
        end
        // rs2 field match: lw x5 then sw x5,0(x1)
        instr_D = 32'h0000A283;
        tick();
        instr_D = 32'h0050A023;
        #1;
        checks++;
        if (hz !== 3'b111) begin failures++; $display("FAIL load_use_rs2 got=%b exp=111", hz); end
        tick();
        // rd = x0 never stalls
        instr_D = 32'h0000A003;
        tick();
        instr_D = 32'h00200333;
        #1;
        checks++;
        if (hz !== 3'b000) begin failures++; $display("FAIL load_x0 got=%b exp=000", hz); end
        // ALU producer never stalls
        instr_D = 32'h002081B3;
        tick();
        instr_D = 32'h003181B3;
        #1;
        checks++;
        if (hz !== 3'b000) begin failures++; $display("FAIL alu_no_stall got=%b exp=000", hz); end
        tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        instr_D = 32'h0020A223;
        valid_D = 1'b1;
        branch_taken_E = 1'b1;
        #1;
        checks++;
        if (hz !== 3'b001) begin failures++; $display("FAIL branch_hazard got=%b exp=001", hz); end
        tick();
        branch_taken_E = 1'b0;
        checks++;
        if (e_bus !== 17'h0) begin failures++; $display("FAIL branch_bubble got=%h exp=0", e_bus); end
        // Load-use and taken branch together: still a bubble
        instr_D = 32'h0000A283;
        tick();
        instr_D = 32'h00228333;
        branch_taken_E = 1'b1;
        #1;
        checks++;
        if (hz !== 3'b111) begin failures++; $display("FAIL branch_and_stall got=%b exp=111", hz); end
        tick();
        branch_taken_E = 1'b0;
        checks++;
        if (e_bus !== 17'h0) begin failures++; $display("FAIL branch_and_stall_bubble got=%h exp=0", e_bus); end
        valid_D = 1'b0;
        tick();
    endtask

    task automatic test_illegal_cnt();
        int n;
        do_reset();
        instr_D = 32'h0000007F;
        valid_D = 1'b1;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n++;
            checks++;
            if (illegal_cnt !== 8'(CNT_ON * n)) begin
                failures++;
                $display("FAIL illegal_cnt_step got=%0d exp=%0d", illegal_cnt, CNT_ON * n);
            end
        end
        checks++;
        if ((e_bus & ILL_M) !== {1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,3'b000,5'd0,1'b1}) begin
            failures++;
            $display("FAIL illegal_flags got=%h", e_bus & ILL_M);
        end
        // Flushed and non-valid illegal instructions are not counted
        branch_taken_E = 1'b1;
        tick();
        branch_taken_E = 1'b0;
        valid_D = 1'b0;
        tick();
        valid_D = 1'b1;
        checks++;
        if (illegal_cnt !== 8'(CNT_ON * n)) begin
            failures++;
            $display("FAIL illegal_cnt_hold got=%0d exp=%0d", illegal_cnt, CNT_ON * n);
        end
        for (int i = 0; i < 298; i++) begin
            tick();
            n++;
        end
        checks++;
        if (illegal_cnt !== 8'(CNT_ON * (n > 255 ? 255 : n))) begin
            failures++;
            $display("FAIL illegal_cnt_sat got=%0d exp=%0d", illegal_cnt, CNT_ON * 255);
        end
        valid_D = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_branch_flush();
        test_illegal_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
